// File: rtl/vga_pkg.sv
// Screen timing, frame-buffer geometry and fill-engine state encoding shared by
// the VGA scan-out, the VRAM arbiter and the sprite renderer.
package vga_pkg;

  localparam logic [9:0] H_VISIBLE = 10'd640;
  localparam logic [9:0] V_VISIBLE = 10'd480;
  localparam logic [9:0] H_TOTAL   = 10'd800;
  localparam logic [9:0] V_TOTAL   = 10'd525;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned ADDR_W   = 15;
  localparam int unsigned FB_W     = 160;
  localparam int unsigned FB_H     = 120;
  localparam int unsigned FB_WORDS = FB_W * FB_H;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StDone
  } fill_state_e;

endpackage

// File: rtl/vga_vram_arbiter_if.sv
// Game-logic write handshake plus the single-port VRAM bus, both owned by the arbiter.
interface vga_vram_arbiter_if
  import vga_pkg::*;
#(
  parameter int unsigned DATA_W = vga_pkg::DATA_W,
  parameter int unsigned ADDR_W = vga_pkg::ADDR_W
) ();

  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic              wr_err;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport master (
    output wr_req, wr_addr, wr_data, ram_rdata,
    input  wr_ack, wr_err, ram_addr, ram_we, ram_wdata
  );

  modport slave (
    input  wr_req, wr_addr, wr_data, ram_rdata,
    output wr_ack, wr_err, ram_addr, ram_we, ram_wdata
  );

endinterface

// File: rtl/fb_addr_gen.sv
// Maps a screen position to its 160-wide frame-buffer word: (y>>2)*160 + (x>>2).
// Takes the counters with the two sub-pixel bits already dropped.
module fb_addr_gen #(
  parameter int unsigned ADDR_W = 15
) (
  input  logic [9:2]        hcnt,
  input  logic [9:2]        vcnt,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] row;
  logic [ADDR_W-1:0] col;

  assign row  = ADDR_W'(vcnt);
  assign col  = ADDR_W'(hcnt);
  // row * 160 as row * 128 + row * 32
  assign addr = (row << 7) + (row << 5) + col;

endmodule

// File: rtl/vga_vram_arbiter.sv
// Shares one synchronous-read VRAM between display reads (every 4th visible cycle)
// and the write port / screen-fill engine, which get every other cycle.
module vga_vram_arbiter
  import vga_pkg::*;
#(
  parameter int unsigned DATA_W   = vga_pkg::DATA_W,
  parameter int unsigned ADDR_W   = vga_pkg::ADDR_W,
  parameter int unsigned FB_W     = vga_pkg::FB_W,
  parameter int unsigned FB_WORDS = vga_pkg::FB_WORDS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        hcnt,
  input  logic [9:0]        vcnt,
  vga_vram_arbiter_if.slave bus,
  input  logic              fill_start,
  input  logic [DATA_W-1:0] fill_color,
  output logic              fill_busy,
  output logic              fill_done,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_on
);

  fill_state_e       state_q;
  logic [ADDR_W-1:0] fill_cnt_q;
  logic [DATA_W-1:0] fill_color_q;

  logic              video_on;
  logic              disp_slot;
  logic [ADDR_W-1:0] disp_addr;

  logic              rd_q;
  logic [1:0]        on_q;
  logic [DATA_W-1:0] pix_q;

  // Each buffer column spans 4 screen pixels, so hcnt>>2 < FB_W is hcnt < 640.
  assign video_on  = (32'(hcnt[9:2]) < FB_W) && (vcnt < V_VISIBLE);
  assign disp_slot = video_on && (hcnt[1:0] == 2'b00);

  fb_addr_gen #(
    .ADDR_W(ADDR_W)
  ) u_fb_addr_gen (
    .hcnt(hcnt[9:2]),
    .vcnt(vcnt[9:2]),
    .addr(disp_addr)
  );

  // Outputs are forced low while reset is held so they clear without waiting for a clock.
  always_comb begin
    bus.wr_ack    = 1'b0;
    bus.wr_err    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_we    = 1'b0;
    bus.ram_wdata = '0;
    if (reset) begin
      if (disp_slot) begin
        bus.ram_addr = disp_addr;
      end else if (state_q == StFill) begin
        bus.ram_addr  = fill_cnt_q;
        bus.ram_we    = 1'b1;
        bus.ram_wdata = fill_color_q;
      end else if ((state_q == StIdle) && bus.wr_req) begin
        bus.wr_ack = 1'b1;
        if (bus.wr_addr < ADDR_W'(FB_WORDS)) begin
          bus.ram_addr  = bus.wr_addr;
          bus.ram_we    = 1'b1;
          bus.ram_wdata = bus.wr_data;
        end else begin
          bus.wr_err = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      fill_cnt_q   <= '0;
      fill_color_q <= '0;
      fill_busy    <= 1'b0;
      fill_done    <= 1'b0;
    end else begin
      fill_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (fill_start) begin
            state_q      <= StFill;
            fill_cnt_q   <= '0;
            fill_color_q <= fill_color;
            fill_busy    <= 1'b1;
          end
        end
        StFill: begin
          if (!disp_slot) begin
            if (fill_cnt_q == ADDR_W'(FB_WORDS - 1)) begin
              state_q   <= StDone;
              fill_done <= 1'b1;
            end else begin
              fill_cnt_q <= fill_cnt_q + ADDR_W'(1);
            end
          end
        end
        StDone: begin
          state_q   <= StIdle;
          fill_busy <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Read data arrives the cycle after a display slot; video_on gets two stages to match.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q  <= 1'b0;
      on_q  <= 2'b00;
      pix_q <= '0;
    end else begin
      rd_q <= disp_slot;
      on_q <= {on_q[0], video_on};
      if (rd_q) begin
        pix_q <= bus.ram_rdata;
      end
    end
  end

  assign pix_on   = on_q[1];
  assign pix_data = pix_on ? pix_q : '0;

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Self-checking bench for vga_vram_arbiter: combinational slot vectors, a pixel
// scoreboard, asynchronous reset mid-fill and a full-buffer fill.
module tb_vga_vram_arbiter;
  import vga_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [9:0] hcnt = '0;
  logic [9:0] vcnt = '0;
  logic       fill_start = 1'b0;
  logic [7:0] fill_color = '0;
  logic       fill_busy, fill_done, pix_on;
  logic [7:0] pix_data;
  logic       preload = 1'b1;

  int checks = 0;
  int fails  = 0;

  vga_vram_arbiter_if #(.DATA_W(8), .ADDR_W(15)) bus ();

  vga_vram_arbiter #(
    .DATA_W(8), .ADDR_W(15), .FB_W(160), .FB_WORDS(19200)
  ) dut (
    .clk(clk), .reset(reset), .hcnt(hcnt), .vcnt(vcnt), .bus(bus),
    .fill_start(fill_start), .fill_color(fill_color), .fill_busy(fill_busy),
    .fill_done(fill_done), .pix_data(pix_data), .pix_on(pix_on)
  );

  always #20 clk = ~clk;

  function automatic logic [7:0] pat(input int i);
    return (i == 19199) ? 8'hA5 : (8'(i) ^ 8'h5A);
  endfunction

  // Synchronous-read single-port RAM model
  logic [7:0] mem [0:32767];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32768; i++) mem[i] <= pat(i);
    end else if (bus.ram_we) begin
      mem[bus.ram_addr] <= bus.ram_wdata;
    end
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ram_addr"}, 32'(bus.ram_addr), 0);
    check({tag, "_ram_we"}, 32'(bus.ram_we), 0);
    check({tag, "_ram_wdata"}, 32'(bus.ram_wdata), 0);
    check({tag, "_wr_ack"}, 32'(bus.wr_ack), 0);
    check({tag, "_wr_err"}, 32'(bus.wr_err), 0);
    check({tag, "_fill_busy"}, 32'(fill_busy), 0);
    check({tag, "_fill_done"}, 32'(fill_done), 0);
    check({tag, "_pix_data"}, 32'(pix_data), 0);
    check({tag, "_pix_on"}, 32'(pix_on), 0);
  endtask

  task automatic adv();
    if (hcnt == 10'd799) begin
      hcnt = '0;
      vcnt = (vcnt == 10'd524) ? 10'd0 : vcnt + 10'd1;
    end else begin
      hcnt = hcnt + 10'd1;
    end
  endtask

  typedef struct {
    logic [9:0]  h, v;
    logic        req;
    logic [14:0] addr;
    logic [7:0]  data;
    logic        ack, we, err;
    logic [14:0] raddr;
    logic [7:0]  wdata;
  } vec_t;
  vec_t vecs[12];

  typedef struct {logic on; logic [7:0] d;} pix_t;
  pix_t       sb[$];
  logic [7:0] last_rd = '0;

  task automatic pix_step(input logic [9:0] h, input logic [9:0] v);
    pix_t e;
    logic vis;
    @(posedge clk); #1;
    hcnt = h;
    vcnt = v;
    vis  = (h < 10'd640) && (v < 10'd480);
    if (vis && (h[1:0] == 2'b00)) last_rd = pat(int'(v / 10'd4) * 160 + int'(h / 10'd4));
    e.on = vis;
    e.d  = vis ? last_rd : 8'h00;
    sb.push_back(e);
    @(negedge clk);
    if (sb.size() == 3) begin
      e = sb.pop_front();
      check($sformatf("pix_on@h%0d", h), 32'(pix_on), 32'(e.on));
      check($sformatf("pix_data@h%0d", h), 32'(pix_data), 32'(e.d));
    end
  endtask

  initial begin
    int exp_addr, bad_writes, bad_acks, cycles;
    logic done_seen, got_ack;

    vecs[0]  = '{10'd0,   10'd0,   1'b0, 15'd0,     8'h00, 1'b0, 1'b0, 1'b0, 15'd0,     8'h00};
    vecs[1]  = '{10'd636, 10'd479, 1'b0, 15'd0,     8'h00, 1'b0, 1'b0, 1'b0, 15'd19199, 8'h00};
    vecs[2]  = '{10'd4,   10'd0,   1'b1, 15'h0123,  8'h3C, 1'b0, 1'b0, 1'b0, 15'd1,     8'h00};
    vecs[3]  = '{10'd5,   10'd0,   1'b1, 15'h0123,  8'h3C, 1'b1, 1'b1, 1'b0, 15'h0123,  8'h3C};
    vecs[4]  = '{10'd700, 10'd10,  1'b1, 15'd19200, 8'h11, 1'b1, 1'b0, 1'b1, 15'd0,     8'h00};
    vecs[5]  = '{10'd640, 10'd0,   1'b0, 15'd0,     8'h00, 1'b0, 1'b0, 1'b0, 15'd0,     8'h00};
    vecs[6]  = '{10'd100, 10'd200, 1'b1, 15'h0055,  8'h66, 1'b0, 1'b0, 1'b0, 15'd8025,  8'h00};
    vecs[7]  = '{10'd102, 10'd200, 1'b1, 15'h7FFF,  8'h01, 1'b1, 1'b0, 1'b1, 15'd0,     8'h00};
    vecs[8]  = '{10'd3,   10'd479, 1'b1, 15'd19199, 8'hEE, 1'b1, 1'b1, 1'b0, 15'd19199, 8'hEE};
    vecs[9]  = '{10'd0,   10'd480, 1'b1, 15'h0010,  8'h20, 1'b1, 1'b1, 1'b0, 15'h0010,  8'h20};
    vecs[10] = '{10'd796, 10'd524, 1'b0, 15'd0,     8'h00, 1'b0, 1'b0, 1'b0, 15'd0,     8'h00};
    vecs[11] = '{10'd4,   10'd4,   1'b0, 15'd0,     8'h00, 1'b0, 1'b0, 1'b0, 15'd161,   8'h00};

    // Reset held from time 0, with a display slot and a pending write on the inputs.
    hcnt = 10'd4;
    bus.wr_req  = 1'b1;
    bus.wr_addr = 15'h0123;
    bus.wr_data = 8'h3C;
    #5;
    check_all_zero("por");
    @(posedge clk); #1;
    preload = 1'b0;
    bus.wr_req = 1'b0;
    #10 reset = 1'b1;

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      hcnt = vecs[i].h;
      vcnt = vecs[i].v;
      bus.wr_req  = vecs[i].req;
      bus.wr_addr = vecs[i].addr;
      bus.wr_data = vecs[i].data;
      @(negedge clk);
      check($sformatf("v%0d_wr_ack", i), 32'(bus.wr_ack), 32'(vecs[i].ack));
      check($sformatf("v%0d_ram_we", i), 32'(bus.ram_we), 32'(vecs[i].we));
      check($sformatf("v%0d_wr_err", i), 32'(bus.wr_err), 32'(vecs[i].err));
      check($sformatf("v%0d_ram_addr", i), 32'(bus.ram_addr), 32'(vecs[i].raddr));
      check($sformatf("v%0d_ram_wdata", i), 32'(bus.ram_wdata), 32'(vecs[i].wdata));
    end

    // Restore the known RAM pattern, then sweep across the end of the visible area.
    @(posedge clk); #1;
    bus.wr_req = 1'b0;
    hcnt = 10'd700;
    preload = 1'b1;
    @(posedge clk); #1;
    preload = 1'b0;
    sb.delete();
    for (int h = 624; h < 648; h++) pix_step(10'(h), 10'd479);
    for (int h = 0; h < 9; h++) pix_step(10'(h), 10'd0);
    sb.delete();

    // Asynchronous reset mid-fill, mid-line.
    @(posedge clk); #1;
    hcnt = 10'd1; vcnt = 10'd0;
    fill_start = 1'b1; fill_color = 8'h33;
    @(posedge clk); #1;
    fill_start = 1'b0; hcnt = 10'd2;
    @(posedge clk); #1;
    hcnt = 10'd8; vcnt = 10'd8;
    bus.wr_req = 1'b1; bus.wr_addr = 15'd5; bus.wr_data = 8'h77;
    #5;
    check("mid_busy_before_reset", 32'(fill_busy), 1);
    check("mid_disp_addr", 32'(bus.ram_addr), 322);
    reset = 1'b0;
    #1;
    check_all_zero("mid");
    #5;
    reset = 1'b1;
    bus.wr_req = 1'b0;
    @(posedge clk); #1;
    hcnt = 10'd0; vcnt = 10'd0;
    @(negedge clk);
    check("post_reset_addr", 32'(bus.ram_addr), 0);
    check("post_reset_we", 32'(bus.ram_we), 0);
    check("post_reset_busy", 32'(fill_busy), 0);
    @(posedge clk); #1;
    hcnt = 10'd1;
    @(negedge clk);
    check("post_reset_no_fill_write", 32'(bus.ram_we), 0);

    // Fill start and a write request in the same idle write slot.
    @(posedge clk); #1;
    hcnt = 10'd1; vcnt = 10'd0;
    fill_start = 1'b1; fill_color = 8'h1F;
    bus.wr_req = 1'b1; bus.wr_addr = 15'h0077; bus.wr_data = 8'h99;
    @(negedge clk);
    check("same_slot_ack", 32'(bus.wr_ack), 1);
    check("same_slot_we", 32'(bus.ram_we), 1);
    check("same_slot_addr", 32'(bus.ram_addr), 32'h77);
    check("same_slot_wdata", 32'(bus.ram_wdata), 32'h99);
    check("same_slot_busy", 32'(fill_busy), 0);
    @(posedge clk); #1;
    fill_start = 1'b0; fill_color = 8'h00;
    bus.wr_addr = 15'h0088; bus.wr_data = 8'h44;
    adv();
    @(negedge clk);
    check("fill_first_busy", 32'(fill_busy), 1);
    check("fill_first_we", 32'(bus.ram_we), 1);
    check("fill_first_addr", 32'(bus.ram_addr), 0);
    check("fill_first_wdata", 32'(bus.ram_wdata), 32'h1F);
    check("fill_first_no_ack", 32'(bus.wr_ack), 0);

    exp_addr = 1; bad_writes = 0; bad_acks = 0; done_seen = 1'b0; cycles = 0;
    while (!done_seen && cycles < 40000) begin
      @(posedge clk); #1;
      adv();
      cycles++;
      @(negedge clk);
      if (bus.ram_we) begin
        if (bus.ram_addr != 15'(exp_addr) || bus.ram_wdata != 8'h1F) bad_writes++;
        exp_addr++;
      end
      if (bus.wr_ack) bad_acks++;
      if (fill_done) done_seen = 1'b1;
    end
    check("fill_done_seen", 32'(done_seen), 1);
    check("fill_write_count", 32'(exp_addr), 19200);
    check("fill_write_seq", 32'(bad_writes), 0);
    check("fill_no_ack_while_busy", 32'(bad_acks), 0);
    check("fill_done_busy", 32'(fill_busy), 1);
    check("fill_mem_first", 32'(mem[0]), 32'h1F);
    check("fill_mem_last", 32'(mem[19199]), 32'h1F);

    got_ack = 1'b0;
    for (int k = 0; k < 20 && !got_ack; k++) begin
      @(posedge clk); #1;
      adv();
      @(negedge clk);
      if (k == 0) begin
        check("fill_done_single_pulse", 32'(fill_done), 0);
        check("fill_busy_falls", 32'(fill_busy), 0);
      end
      if (bus.wr_ack) begin
        got_ack = 1'b1;
        check("pending_ack_addr", 32'(bus.ram_addr), 32'h88);
        check("pending_ack_wdata", 32'(bus.ram_wdata), 32'h44);
        check("pending_ack_not_busy", 32'(fill_busy), 0);
      end
    end
    check("pending_ack_seen", 32'(got_ack), 1);

    @(posedge clk); #1;
    bus.wr_req = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
